// File: rtl/aq_jpeg_hdr_gen.sv
// Baseline JPEG marker-stream generator: SOI, DQT, SOF0, DHT, optional DRI, SOS.
// Optional DRI segment is compiled in with AQ_JPEG_HDR_DRI_EN.
module aq_jpeg_hdr_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [15:0] Width,
  input  logic [15:0] Height,
  input  logic [2:0]  JpegComp,
  input  logic [1:0]  SubSamplingW,
  input  logic [1:0]  SubSamplingH,
  input  logic [15:0] JpegRestart,
  output logic        DqtTable,
  output logic [5:0]  DqtCount,
  input  logic [7:0]  DqtData,
  output logic [1:0]  DhtTable,
  output logic [7:0]  DhtAddr,
  input  logic [7:0]  DhtData,
  input  logic [7:0]  DhtNum,
  output logic        OutValid,
  output logic [7:0]  OutData,
  output logic        OutLast,
  input  logic        OutReady,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {
    StIdle, StSoi, StDqt, StSof, StDht,
`ifdef AQ_JPEG_HDR_DRI_EN
    StDri,
`endif
    StSos, StLast
  } stateT;

  stateT       stateQ, stateD, nextSeg, afterDht;
  logic [7:0]  idxQ, idxD, idxOff, sosIdx, byteVal, nf;
  logic        dqtTabQ, dqtTabD;
  logic [1:0]  dhtTabQ, dhtTabD;
  logic [15:0] widthQ, widthD, heightQ, heightD;
  logic        threeQ, threeD;
  logic [1:0]  sswQ, sswD, sshQ, sshD;
  logic        outValidQ, outValidD, outLastQ, outLastD, doneQ, doneD;
  logic [7:0]  outDataQ, outDataD;
  logic [15:0] sofLen, sosLen, dhtLen;
  logic        segEnd;
`ifdef AQ_JPEG_HDR_DRI_EN
  logic [15:0] restartQ, restartD;
`else
  logic        unusedRestart;
  assign unusedRestart = ^JpegRestart;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ    <= StIdle;
      idxQ      <= 8'd0;
      dqtTabQ   <= 1'b0;
      dhtTabQ   <= 2'd0;
      widthQ    <= 16'd0;
      heightQ   <= 16'd0;
      threeQ    <= 1'b0;
      sswQ      <= 2'd0;
      sshQ      <= 2'd0;
      outValidQ <= 1'b0;
      outDataQ  <= 8'd0;
      outLastQ  <= 1'b0;
      doneQ     <= 1'b0;
`ifdef AQ_JPEG_HDR_DRI_EN
      restartQ  <= 16'd0;
`endif
    end else begin
      stateQ    <= stateD;
      idxQ      <= idxD;
      dqtTabQ   <= dqtTabD;
      dhtTabQ   <= dhtTabD;
      widthQ    <= widthD;
      heightQ   <= heightD;
      threeQ    <= threeD;
      sswQ      <= sswD;
      sshQ      <= sshD;
      outValidQ <= outValidD;
      outDataQ  <= outDataD;
      outLastQ  <= outLastD;
      doneQ     <= doneD;
`ifdef AQ_JPEG_HDR_DRI_EN
      restartQ  <= restartD;
`endif
    end
  end

  always_comb begin
    nf     = threeQ ? 8'd3 : 8'd1;
    sofLen = 16'd8 + 16'd3 * {8'd0, nf};
    sosLen = 16'd6 + 16'd2 * {8'd0, nf};
    dhtLen = 16'd19 + {8'd0, DhtNum};
    idxOff = idxQ - 8'd5;
    // Grayscale SOS skips the two extra component pairs.
    sosIdx = (!threeQ && idxQ >= 8'd7) ? idxQ + 8'd4 : idxQ;
`ifdef AQ_JPEG_HDR_DRI_EN
    afterDht = (restartQ != 16'd0) ? StDri : StSos;
`else
    afterDht = StSos;
`endif
    byteVal = 8'h00;
    segEnd  = 1'b0;
    nextSeg = StIdle;
    case (stateQ)
      StSoi: begin
        byteVal = (idxQ == 8'd0) ? 8'hFF : 8'hD8;
        segEnd  = (idxQ == 8'd1);
        nextSeg = StDqt;
      end
      StDqt: begin
        case (idxQ)
          8'd0:    byteVal = 8'hFF;
          8'd1:    byteVal = 8'hDB;
          8'd2:    byteVal = 8'h00;
          8'd3:    byteVal = 8'h43;
          8'd4:    byteVal = {7'd0, dqtTabQ};
          default: byteVal = DqtData;
        endcase
        segEnd  = (idxQ == 8'd68);
        nextSeg = (threeQ && !dqtTabQ) ? StDqt : StSof;
      end
      StSof: begin
        case (idxQ)
          8'd0:    byteVal = 8'hFF;
          8'd1:    byteVal = 8'hC0;
          8'd2:    byteVal = sofLen[15:8];
          8'd3:    byteVal = sofLen[7:0];
          8'd4:    byteVal = 8'h08;
          8'd5:    byteVal = heightQ[15:8];
          8'd6:    byteVal = heightQ[7:0];
          8'd7:    byteVal = widthQ[15:8];
          8'd8:    byteVal = widthQ[7:0];
          8'd9:    byteVal = nf;
          8'd10:   byteVal = 8'h01;
          8'd11:   byteVal = {2'b00, sswQ, 2'b00, sshQ};
          8'd13:   byteVal = 8'h02;
          8'd14:   byteVal = 8'h11;
          8'd15:   byteVal = 8'h01;
          8'd16:   byteVal = 8'h03;
          8'd17:   byteVal = 8'h11;
          8'd18:   byteVal = 8'h01;
          default: byteVal = 8'h00;
        endcase
        segEnd  = (idxQ == (threeQ ? 8'd18 : 8'd12));
        nextSeg = StDht;
      end
      StDht: begin
        case (idxQ)
          8'd0:    byteVal = 8'hFF;
          8'd1:    byteVal = 8'hC4;
          8'd2:    byteVal = dhtLen[15:8];
          8'd3:    byteVal = dhtLen[7:0];
          8'd4:    byteVal = {3'b000, dhtTabQ[0], 3'b000, dhtTabQ[1]};
          default: byteVal = DhtData;
        endcase
        segEnd  = ({1'b0, idxQ} == 9'd20 + {1'b0, DhtNum});
        nextSeg = (dhtTabQ == 2'd3 || (!threeQ && dhtTabQ == 2'd1)) ? afterDht : StDht;
      end
`ifdef AQ_JPEG_HDR_DRI_EN
      StDri: begin
        case (idxQ)
          8'd0:    byteVal = 8'hFF;
          8'd1:    byteVal = 8'hDD;
          8'd2:    byteVal = 8'h00;
          8'd3:    byteVal = 8'h04;
          8'd4:    byteVal = restartQ[15:8];
          default: byteVal = restartQ[7:0];
        endcase
        segEnd  = (idxQ == 8'd5);
        nextSeg = StSos;
      end
`endif
      StSos: begin
        case (sosIdx)
          8'd0:    byteVal = 8'hFF;
          8'd1:    byteVal = 8'hDA;
          8'd2:    byteVal = sosLen[15:8];
          8'd3:    byteVal = sosLen[7:0];
          8'd4:    byteVal = nf;
          8'd5:    byteVal = 8'h01;
          8'd7:    byteVal = 8'h02;
          8'd8:    byteVal = 8'h11;
          8'd9:    byteVal = 8'h03;
          8'd10:   byteVal = 8'h11;
          8'd12:   byteVal = 8'h3F;
          default: byteVal = 8'h00;
        endcase
        segEnd  = (sosIdx == 8'd13);
        nextSeg = StLast;
      end
      default: ;
    endcase

    stateD    = stateQ;
    idxD      = idxQ;
    dqtTabD   = dqtTabQ;
    dhtTabD   = dhtTabQ;
    widthD    = widthQ;
    heightD   = heightQ;
    threeD    = threeQ;
    sswD      = sswQ;
    sshD      = sshQ;
    outValidD = outValidQ;
    outDataD  = outDataQ;
    outLastD  = outLastQ;
    doneD     = 1'b0;
`ifdef AQ_JPEG_HDR_DRI_EN
    restartD  = restartQ;
`endif
    if (stateQ == StIdle) begin
      if (Start) begin
        widthD    = Width;
        heightD   = Height;
        threeD    = (JpegComp != 3'd1);
        sswD      = SubSamplingW;
        sshD      = SubSamplingH;
`ifdef AQ_JPEG_HDR_DRI_EN
        restartD  = JpegRestart;
`endif
        // The SOI FF byte is emitted straight from Idle.
        stateD    = StSoi;
        idxD      = 8'd1;
        dqtTabD   = 1'b0;
        dhtTabD   = 2'd0;
        outValidD = 1'b1;
        outDataD  = 8'hFF;
        outLastD  = 1'b0;
      end
    end else if (stateQ == StLast) begin
      if (OutReady) begin
        stateD    = StIdle;
        outValidD = 1'b0;
        outLastD  = 1'b0;
        doneD     = 1'b1;
      end
    end else if (!outValidQ || OutReady) begin
      outValidD = 1'b1;
      outDataD  = byteVal;
      outLastD  = (stateQ == StSos) && segEnd;
      if (segEnd) begin
        stateD = nextSeg;
        idxD   = 8'd0;
        if (stateQ == StDqt && nextSeg == StDqt) dqtTabD = 1'b1;
        if (stateQ == StDht && nextSeg == StDht) dhtTabD = dhtTabQ + 2'd1;
      end else begin
        idxD = idxQ + 8'd1;
      end
    end
  end

  assign OutValid = outValidQ;
  assign OutData  = outDataQ;
  assign OutLast  = outLastQ;
  assign Done     = doneQ;
  assign Busy     = (stateQ != StIdle);
  assign DqtTable = dqtTabQ;
  assign DhtTable = dhtTabQ;
  assign DqtCount = (stateQ == StDqt && idxQ >= 8'd5) ? idxOff[5:0] : 6'd0;
  assign DhtAddr  = (stateQ == StDht && idxQ >= 8'd5) ? idxOff : 8'd0;

endmodule
